// File: rtl/data_transfer_pkg.sv
// Shared types and constants for the D-format data transfer memory.
package data_transfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DWORD_BYTES = 8;

  // 11-bit D-format opcodes.
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;

endpackage

// File: rtl/data_transfer_byte_ram.sv
// Single-port byte RAM: synchronous write, asynchronous read, contents not reset.
module data_transfer_byte_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**ADDR_W];

  // Byte write on the rising edge when enabled.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_transfer_mem.sv
// Byte-serial data memory responder for LDUR/STUR/LDURB/STURB.
// Optional feature macro: DATA_TRANSFER_BYTE_OPS_EN (byte ops honoured when
// defined; otherwise every request is handled as a doubleword).
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | one byte per edge at addr+cnt
// RESP   | response held until consumed
module data_transfer_mem
  import data_transfer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt;
  logic              r_write;
  logic              r_byte;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;

  logic              w_req_byte;
  logic              w_accept;
  logic              w_bad;
  logic              w_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [7:0]        w_mem_wdata;
  logic [7:0]        w_mem_rdata;

`ifdef DATA_TRANSFER_BYTE_OPS_EN
  assign w_req_byte = req_byte;
`else
  // Port kept for interface compatibility; every request is a doubleword.
  assign w_req_byte = req_byte & 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && req_valid;
  // Misaligned doubleword or any address bit above the memory range.
  assign w_bad    = (!w_req_byte && (req_addr[2:0] != 3'd0)) ||
                    ((req_addr >> ADDR_W) != 64'd0);
  assign w_last   = r_byte ? (r_cnt == 3'd0) : (r_cnt == 3'(DWORD_BYTES - 1));

  assign w_mem_addr  = r_addr + ADDR_W'(r_cnt);
  assign w_mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
  assign w_we        = (r_state == ACCESS) && r_write;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = (r_state == RESP) ? r_rdata : 64'd0;
  assign rsp_err   = (r_state == RESP) && r_err;

  data_transfer_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = w_bad ? RESP : ACCESS;
      ACCESS:  if (w_last) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, request latch, byte counter and load accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_byte  <= w_req_byte;
        r_addr  <= req_addr[ADDR_W-1:0];
        r_wdata <= req_wdata;
        r_rdata <= 64'd0;
        r_err   <= w_bad;
        r_cnt   <= 3'd0;
      end else if (r_state == ACCESS) begin
        if (!r_write) r_rdata[{r_cnt, 3'b000} +: 8] <= w_mem_rdata;
        r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_transfer_mem.sv
module tb_data_transfer_mem;
  import data_transfer_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MEM_BYTES = 1 << ADDR_W;
`ifdef DATA_TRANSFER_BYTE_OPS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [MEM_BYTES];

  data_transfer_mem #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: rules stated directly on byte addresses, whole transfer at once.
  function automatic void model_op(input bit w, input bit b, input logic [63:0] a,
                                   input logic [63:0] d, output bit err,
                                   output logic [63:0] rd, output int lat);
    int n;
    n   = (b && BYTE_EN) ? 1 : DWORD_BYTES;
    rd  = 64'd0;
    err = ((n == DWORD_BYTES) && (a % 8 != 0)) || (a >= 64'(MEM_BYTES));
    lat = 0;
    if (!err) begin
      lat = n;
      for (int i = 0; i < n; i++) begin
        if (w) mdl[int'(a) + i] = d[8*i +: 8];
        else   rd[8*i +: 8]     = mdl[int'(a) + i];
      end
    end
  endfunction

  task automatic issue(input logic [10:0] op, input logic [63:0] a, input logic [63:0] d);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = (op == OP_STUR) || (op == OP_STURB);
    req_byte  = (op == OP_STURB) || (op == OP_LDURB);
    req_addr  = a;
    req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [10:0] op, input logic [63:0] a,
                       input logic [63:0] d, output logic [63:0] rd);
    bit          e_err;
    logic [63:0] e_rd;
    int          e_lat, lat;
    model_op((op == OP_STUR) || (op == OP_STURB), (op == OP_STURB) || (op == OP_LDURB),
             a, d, e_err, e_rd, e_lat);
    issue(op, a, d);
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(e_lat));
    chk({tag, "_err"}, 64'(rsp_err), 64'(e_err));
    chk({tag, "_rdata"}, rsp_rdata, e_rd);
    rd = rsp_rdata;
    consume();
  endtask

  initial begin
    logic [63:0] rd, held;
    logic [10:0] op;
    logic [63:0] a, d;
    int          lat;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < MEM_BYTES; i += 8)
      do_op("prefill", OP_STUR, 64'(i), {$urandom, $urandom}, rd);

    do_op("stur08", OP_STUR, 64'h08, 64'h0123456789ABCDEF, rd);
    chk("stur08_lit", rd, 64'd0);
    do_op("ldur08", OP_LDUR, 64'h08, 64'd0, rd);
    chk("ldur08_lit", rd, 64'h0123456789ABCDEF);

    do_op("sturb09", OP_STURB, 64'h09, 64'hFFFFFFFFFFFFFF5A, rd);
    do_op("ldur08b", OP_LDUR, 64'h08, 64'd0, rd);
`ifdef DATA_TRANSFER_BYTE_OPS_EN
    chk("ldur08b_lit", rd, 64'h0123456789AB5AEF);
    do_op("ldurb09", OP_LDURB, 64'h09, 64'd0, rd);
    chk("ldurb09_lit", rd, 64'h000000000000005A);
`else
    chk("ldur08b_lit", rd, 64'h0123456789ABCDEF);
    do_op("sturb08_dw", OP_STURB, 64'h08, 64'h0123456789ABCDEF, rd);
    do_op("ldur08c", OP_LDUR, 64'h08, 64'd0, rd);
    chk("ldur08c_lit", rd, 64'h0123456789ABCDEF);
`endif

    do_op("ldur0c_err", OP_LDUR, 64'h0C, 64'd0, rd);
    do_op("stur100_err", OP_STUR, 64'h100, 64'hDEADBEEFDEADBEEF, rd);
    do_op("ldur08_after_err", OP_LDUR, 64'h08, 64'd0, rd);

    // Backpressure on a load response with a competing request present.
    issue(OP_LDUR, 64'h08, 64'd0);
    wait_rsp(lat);
    chk("bp_lat", 64'(lat), 64'd8);
    held = rsp_rdata;
    chk("bp_rdata", held, {mdl[15], mdl[14], mdl[13], mdl[12], mdl[11], mdl[10], mdl[9], mdl[8]});
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = 64'h08; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold", rsp_rdata, held);
      chk("bp_err", 64'(rsp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    consume();
    chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
    do_op("bp_not_stored", OP_LDUR, 64'h08, 64'd0, rd);

    // Reset in the middle of a doubleword store.
    do_op("fill10", OP_STUR, 64'h10, 64'hAAAAAAAAAAAAAAAA, rd);
    issue(OP_STUR, 64'h10, 64'h1122334455667788);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rdata", rsp_rdata, 64'd0);
    chk("mid_rst_err", 64'(rsp_err), 64'd0);
    mdl[16] = 8'h88; mdl[17] = 8'h77; mdl[18] = 8'h66;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
    do_op("ldur10", OP_LDUR, 64'h10, 64'd0, rd);
    chk("ldur10_lit", rd, 64'hAAAAAAAAAA667788);

    // Randomized mix of loads/stores, byte/doubleword, some illegal addresses.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(3))
        0: op = OP_STUR;
        1: op = OP_LDUR;
        2: op = OP_STURB;
        default: op = OP_LDURB;
      endcase
      case ($urandom_range(9))
        0: a = 64'($urandom_range(MEM_BYTES - 1));
        1: a = 64'(MEM_BYTES) + 64'($urandom_range(1000));
        default: a = 64'($urandom_range(MEM_BYTES / 8 - 1) * 8) + 64'($urandom_range(1) * $urandom_range(7));
      endcase
      d = {$urandom, $urandom};
      do_op("rand", op, a, d, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
